// File: rtl/mul8_seq_ctrl.sv
// Sequential shift-and-add 8x8 unsigned multiplier controller driving an external ripple adder.
// Optional MUL_EARLY_TERM_EN: finish early once the remaining multiplier bits are all zero.
module mul8_seq_ctrl #(
  parameter int unsigned MUL_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [MUL_W-1:0]   cmd_a,
  input  logic [MUL_W-1:0]   cmd_b,
  output logic [MUL_W-1:0]   add_a,
  output logic [MUL_W-1:0]   add_b,
  output logic               add_cin,
  input  logic [MUL_W-1:0]   add_sum,
  input  logic               add_cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*MUL_W-1:0] res_product,
  output logic               res_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [MUL_W-1:0]   m;
  logic [MUL_W-1:0]   p_hi;
  logic [MUL_W-1:0]   p_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*MUL_W-1:0] step;
  logic [2*MUL_W-1:0] nxt;
  logic               last;

  // Adder is combinational: its sum/cout are consumed in the same RUN cycle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == S_RUN) begin
      add_a = p_hi;
      add_b = p_lo[0] ? m : '0;
    end
  end

  assign add_cin = 1'b0;
  assign step    = {add_cout, add_sum, p_lo[MUL_W-1:1]};

`ifdef MUL_EARLY_TERM_EN
  logic [MUL_W-1:0] rem_mask;
  logic             rem_zero;
  logic [CNT_W-1:0] shamt;

  // All remaining iterations would only shift in zeros, so collapse them into one shift.
  always_comb begin
    rem_mask = {MUL_W{1'b1}} >> cnt;
    rem_zero = (p_lo & rem_mask) == '0;
    shamt    = CNT_W'(MUL_W) - cnt;
    nxt      = rem_zero ? ({p_hi, p_lo} >> shamt) : step;
    last     = rem_zero || (cnt == CNT_W'(MUL_W - 1));
  end
`else
  always_comb begin
    nxt  = step;
    last = (cnt == CNT_W'(MUL_W - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_product <= '0;
      res_ovf     <= 1'b0;
      cnt         <= '0;
      m           <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            m         <= cmd_a;
            p_hi      <= '0;
            p_lo      <= cmd_b;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          {p_hi, p_lo} <= nxt;
          cnt          <= cnt + 1'b1;
          if (last) begin
            state       <= S_DONE;
            res_valid   <= 1'b1;
            res_product <= nxt;
            res_ovf     <= |nxt[2*MUL_W-1:MUL_W];
          end
        end
        S_DONE: begin
          // cmd_ready stays low on the handshake edge, so no command overlaps it.
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: random operands against a plain a*b reference,
// with a behavioural adder model standing in for full_adder_8bit.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_product;
  logic        res_ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;

  mul8_seq_ctrl #(.MUL_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product), .res_ovf(res_ovf)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Cycles from accept edge T to the cycle in which res_valid is first seen (cycle n ends at edge n).
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_TERM_EN
    int top;
    int run;
    if (b == 8'h00) return 2;
    top = 0;
    for (int i = 0; i < 8; i++) if (b[i]) top = i;
    run = top + 2;
    if (run > 8) run = 8;
    return run + 1;
`else
    return 9;
`endif
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL issue_ready got cmd_ready=%b want 1 within 30 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = cyc + 1 - acc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    tests++; if (res_product !== 16'h0000) begin fails++; $display("FAIL reset_product got %h want 0000", res_product); end
    tests++; if (res_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", res_ovf); end
    tests++; if ({add_a, add_b, add_cin} !== 17'h0) begin fails++; $display("FAIL reset_adder_in got %h/%h/%b want 0", add_a, add_b, add_cin); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit to;
    issue(8'h0F, 8'h11);
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL basic_busy cmd_ready got %b want 0", cmd_ready); end
    wait_valid(lat, to);
    tests++; if (to || lat != exp_lat(8'h11)) begin fails++; $display("FAIL basic_latency got %0d (timeout %0b) want %0d", lat, to, exp_lat(8'h11)); end
    tests++; if (res_product !== 16'h00FF) begin fails++; $display("FAIL basic_product got %h want 00ff", res_product); end
    tests++; if (res_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b want 0", res_ovf); end
    handshake();
    tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL basic_release got ready=%b valid=%b want 1/0", cmd_ready, res_valid); end
  endtask

  task automatic test_max();
    int lat; bit to;
    issue(8'hFF, 8'hFF);
    wait_valid(lat, to);
    tests++; if (to || lat != exp_lat(8'hFF)) begin fails++; $display("FAIL max_latency got %0d (timeout %0b) want %0d", lat, to, exp_lat(8'hFF)); end
    tests++; if (res_product !== 16'hFE01) begin fails++; $display("FAIL max_product got %h want fe01", res_product); end
    tests++; if (res_ovf !== 1'b1) begin fails++; $display("FAIL max_ovf got %b want 1", res_ovf); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    logic [7:0] a, b;
    logic [15:0] exp;
    a = 8'($urandom_range(16, 255));
    b = 8'($urandom_range(16, 255));
    exp = 16'(a) * 16'(b);
    issue(a, b);
    wait_valid(lat, to);
    tests++; if (to) begin fails++; $display("FAIL bp_timeout got no res_valid want res_valid"); end
    cmd_valid = 1'b1;
    cmd_a = 8'h02;
    cmd_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b1 || res_product !== exp || res_ovf !== (exp > 16'h00FF) || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d] got v=%b p=%h o=%b rdy=%b want 1/%h/%b/0", i, res_valid, res_product, res_ovf, cmd_ready, exp, exp > 16'h00FF);
      end
    end
    cmd_valid = 1'b0;
    handshake();
    tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", cmd_ready, res_valid); end
  endtask

  task automatic test_reset_midop();
    int lat; bit to;
    issue(8'hA5, 8'h3C);
    repeat (4) @(negedge clk);
    tests++; if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL midop_busy got ready=%b valid=%b want 0/0", cmd_ready, res_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_product !== 16'h0 || res_ovf !== 1'b0) begin
      fails++;
      $display("FAIL midop_idle got ready=%b valid=%b p=%h ovf=%b want 1/0/0000/0", cmd_ready, res_valid, res_product, res_ovf);
    end
    issue(8'h03, 8'h05);
    wait_valid(lat, to);
    tests++; if (to || lat != exp_lat(8'h05)) begin fails++; $display("FAIL midop_latency got %0d (timeout %0b) want %0d", lat, to, exp_lat(8'h05)); end
    tests++; if (res_product !== 16'h000F) begin fails++; $display("FAIL midop_product got %h want 000f", res_product); end
    handshake();
  endtask

  task automatic test_zero();
    int lat; bit to;
    logic [7:0] ops [4];
    ops[0] = 8'h00; ops[1] = 8'($urandom_range(1, 255));
    ops[2] = 8'($urandom_range(1, 255)); ops[3] = 8'h00;
    for (int k = 0; k < 4; k += 2) begin
      issue(ops[k], ops[k+1]);
      wait_valid(lat, to);
      tests++; if (to || lat != exp_lat(ops[k+1])) begin fails++; $display("FAIL zero_latency[%0d] got %0d (timeout %0b) want %0d", k, lat, to, exp_lat(ops[k+1])); end
      tests++; if (res_product !== 16'h0 || res_ovf !== 1'b0) begin fails++; $display("FAIL zero_product[%0d] got %h/%b want 0000/0", k, res_product, res_ovf); end
      handshake();
    end
  endtask

  task automatic test_random();
    int lat; bit to;
    logic [7:0] a, b;
    logic [15:0] exp;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp = 16'(a) * 16'(b);
      issue(a, b);
      wait_valid(lat, to);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tests++;
      if (to || lat != exp_lat(b) || res_product !== exp || res_ovf !== (exp > 16'h00FF)) begin
        fails++;
        $display("FAIL random[%0d] %h*%h got p=%h o=%b lat=%0d want p=%h o=%b lat=%0d", n, a, b, res_product, res_ovf, lat, exp, exp > 16'h00FF, exp_lat(b));
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    logic [7:0] a, b;
    logic [15:0] exp;
    issue(8'h12, 8'h34);
    wait_valid(lat, to);
    a = 8'($urandom);
    b = 8'($urandom);
    exp = 16'(a) * 16'(b);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap got ready=%b valid=%b want 1/0", cmd_ready, res_valid); end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept got cmd_ready=%b want 0", cmd_ready); end
    wait_valid(lat, to);
    tests++;
    if (to || lat != exp_lat(b) || res_product !== exp) begin
      fails++;
      $display("FAIL b2b_result %h*%h got p=%h lat=%0d want p=%h lat=%0d", a, b, res_product, lat, exp, exp_lat(b));
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_midop();
    test_zero();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
